// File: rtl/track_sequencer.sv
// track_sequencer
//   Track selector and play-state controller for the music player. Turns
//   debounced button pulses and the player's end-of-track pulse into a
//   registered track index plus play/pause state, with four play modes
//   (loop, repeat-one, shuffle, stop-at-end). Shuffle keeps a bounded LIFO
//   history so prev retraces shuffled picks.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   next, prev      single-cycle track selection pulses
//   play_toggle     single-cycle play/pause pulse
//   track_done      single-cycle end-of-track pulse from the player
//   mode            0 LOOP, 1 REPEAT_ONE, 2 SHUFFLE, 3 STOP_AT_END
//   track           current track index (registered)
//   playing/paused  registered play-state decodes
//   track_changed   one-cycle pulse with every new or restarted track
//   hist_count      number of valid shuffle history entries
module track_sequencer #(
    parameter int          NUM_TRACKS = 4,
    parameter int          TRACK_W    = 2,
    parameter int          HIST_DEPTH = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          next,
    input  logic                          prev,
    input  logic                          play_toggle,
    input  logic                          track_done,
    input  logic [1:0]                    mode,
    output logic [TRACK_W-1:0]            track,
    output logic                          playing,
    output logic                          paused,
    output logic                          track_changed,
    output logic [$clog2(HIST_DEPTH):0]   hist_count
);

    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TRACK_W-1:0] LAST      = TRACK_W'(NUM_TRACKS - 1);
    localparam logic [TRACK_W:0]   NUM_EXT   = (TRACK_W + 1)'(NUM_TRACKS);
    localparam logic [CNT_W-1:0]   HIST_FULL = CNT_W'(HIST_DEPTH);

    localparam logic [1:0] M_LOOP    = 2'd0;
    localparam logic [1:0] M_REPEAT  = 2'd1;
    localparam logic [1:0] M_SHUFFLE = 2'd2;
    localparam logic [1:0] M_STOP    = 2'd3;

    typedef enum logic [1:0] {STOPPED, PLAYING, PAUSED} state_t;

    function automatic logic [TRACK_W-1:0] inc_trk(input logic [TRACK_W-1:0] t);
        return (t == LAST) ? '0 : t + TRACK_W'(1);
    endfunction

    function automatic logic [TRACK_W-1:0] dec_trk(input logic [TRACK_W-1:0] t);
        return (t == '0) ? LAST : t - TRACK_W'(1);
    endfunction

    state_t               state, state_nx;
    logic [15:0]          lfsr;
    logic [TRACK_W-1:0]   hist_mem [HIST_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [TRACK_W-1:0]   pick_raw, pick_wrap, pick, track_nx;
    logic                 ev_next, ev_prev, ev_done, shuf, do_push, do_pop, stop_wrap;

    always_comb begin
        // one track event per cycle: next > prev > track_done
        ev_next   = next;
        ev_prev   = prev & ~next;
        ev_done   = track_done & ~next & ~prev & (state == PLAYING);
        shuf      = (mode == M_SHUFFLE);
        do_push   = shuf & (ev_next | ev_done);
        do_pop    = shuf & ev_prev & (hist_count != '0);
        stop_wrap = ev_done & (mode == M_STOP) & (track == LAST);
        rd_ptr    = wr_ptr - PTR_W'(1);

        // fold the LFSR slice into range; since NUM_TRACKS > 2**(TRACK_W-1)
        // one subtraction suffices, then step off the current track
        pick_raw  = lfsr[TRACK_W-1:0];
        pick_wrap = ({1'b0, pick_raw} >= NUM_EXT) ? pick_raw - TRACK_W'(NUM_TRACKS) : pick_raw;
        pick      = (pick_wrap == track) ? inc_trk(track) : pick_wrap;

        track_nx = track;
        if (do_push)
            track_nx = pick;
        else if (do_pop)
            track_nx = hist_mem[rd_ptr];
        else if (ev_next)
            track_nx = inc_trk(track);
        else if (ev_prev)
            track_nx = dec_trk(track);      // also the empty-history shuffle fallback
        else if (ev_done && mode != M_REPEAT)
            track_nx = inc_trk(track);      // LOOP, and STOP_AT_END (wraps LAST to 0)

        // stop-at-end completion wins over a same-cycle play_toggle
        state_nx = state;
        if (stop_wrap)
            state_nx = STOPPED;
        else if (play_toggle) begin
            case (state)
                STOPPED: state_nx = PLAYING;
                PLAYING: state_nx = PAUSED;
                PAUSED:  state_nx = PLAYING;
                default: state_nx = STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= STOPPED;
            playing       <= 1'b0;
            paused        <= 1'b0;
            track         <= '0;
            track_changed <= 1'b0;
            hist_count    <= '0;
            wr_ptr        <= '0;
            lfsr          <= LFSR_SEED;
            for (int i = 0; i < HIST_DEPTH; i++)
                hist_mem[i] <= '0;
        end else begin
            // taps 16,14,13,11 -> bits 15,13,12,10
            lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            state         <= state_nx;
            playing       <= (state_nx == PLAYING);
            paused        <= (state_nx == PAUSED);
            track         <= track_nx;
            track_changed <= ev_next | ev_prev | ev_done;

            // circular LIFO: a push when full overwrites the oldest slot,
            // which is the slot the write pointer lands on after wrapping
            if (do_push) begin
                hist_mem[wr_ptr] <= track;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end else if (do_pop) begin
                wr_ptr           <= rd_ptr;
            end

            if (!shuf)
                hist_count <= '0;
            else if (do_push)
                hist_count <= (hist_count == HIST_FULL) ? HIST_FULL : hist_count + CNT_W'(1);
            else if (do_pop)
                hist_count <= hist_count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Testbench for track_sequencer: directed scenarios plus randomized pulses,
// every cycle checked against a queue-based behavioural model.
module tb_track_sequencer;

    localparam int N  = 4;
    localparam int TW = 2;
    localparam int HD = 8;
    localparam int CW = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          next = 1'b0, prev = 1'b0, play_toggle = 1'b0, track_done = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [TW-1:0] track;
    logic          playing, paused, track_changed;
    logic [CW-1:0] hist_count;

    track_sequencer #(.NUM_TRACKS(N), .TRACK_W(TW), .HIST_DEPTH(HD), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .next(next), .prev(prev), .play_toggle(play_toggle),
        .track_done(track_done), .mode(mode), .track(track), .playing(playing),
        .paused(paused), .track_changed(track_changed), .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    // model: 0 stopped, 1 playing, 2 paused
    int          m_track, m_state;
    bit          m_tc;
    int          hq[$];
    logic [15:0] m_lfsr;
    int          n_pass = 0, n_total = 0;

    function automatic int inc(input int t); return (t + 1) % N; endfunction
    function automatic int dec(input int t); return (t + N - 1) % N; endfunction

    function automatic logic [TW+3+CW-1:0] expected();
        return {TW'(m_track), m_state == 1, m_state == 2, m_tc, CW'(hq.size())};
    endfunction

    function automatic logic [TW+3+CW-1:0] actual();
        return {track, playing, paused, track_changed, hist_count};
    endfunction

    task automatic model_reset();
        m_track = 0; m_state = 0; m_tc = 0; m_lfsr = SEED; hq.delete();
    endtask

    task automatic model_edge();
        int ev, p;
        bit stop;
        ev = next ? 1 : prev ? 2 : (track_done && m_state == 1) ? 3 : 0;
        stop = (ev == 3 && mode == 3 && m_track == N - 1);
        p = int'(m_lfsr) % (1 << TW);
        if (p >= N) p -= N;
        if (p == m_track) p = inc(m_track);
        if (mode == 2 && (ev == 1 || ev == 3)) begin
            hq.push_back(m_track);
            if (hq.size() > HD) void'(hq.pop_front());
            m_track = p;
        end else if (ev == 2) begin
            if (mode == 2 && hq.size() > 0) m_track = hq.pop_back();
            else m_track = dec(m_track);
        end else if (ev == 1 || (ev == 3 && mode != 1)) begin
            m_track = inc(m_track);
        end
        if (mode != 2) hq.delete();
        if (stop) m_state = 0;
        else if (play_toggle) m_state = (m_state == 1) ? 2 : 1;
        m_tc = (ev != 0);
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    endtask

    // drive one cycle of pulses, update the model at the edge, sample 1 ns later
    task automatic step(input bit n, input bit p, input bit pt, input bit td);
        next = n; prev = p; play_toggle = pt; track_done = td;
        @(posedge clk);
        model_edge();
        #1;
        next = 0; prev = 0; play_toggle = 0; track_done = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_total++;
        if (actual() !== '0) $display("FAIL reset_state: got %h want 0", actual());
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_loop_next();
        int seq[5] = '{1, 2, 3, 0, 1};
        mode = 2'd0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            n_total++;
            if (int'(track) !== seq[i] || track_changed !== 1'b1 || actual() !== expected())
                $display("FAIL loop_next[%0d]: got track %0d tc %b (%h) want track %0d tc 1 (%h)",
                         i, track, track_changed, actual(), seq[i], expected());
            else n_pass++;
        end
        step(0, 1, 0, 0);
        n_total++;
        if (track !== 2'd0 || actual() !== expected()) $display("FAIL loop_prev0: got %0d want 0", track);
        else n_pass++;
        step(0, 1, 0, 0);
        n_total++;
        if (track !== 2'd3 || actual() !== expected()) $display("FAIL loop_prev3: got %0d want 3", track);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (track_changed !== 1'b0 || track !== 2'd3) $display("FAIL loop_idle: got tc %b track %0d want tc 0 track 3", track_changed, track);
        else n_pass++;
    endtask

    task automatic test_play_state();
        logic [2:0] want[2] = '{3'b100, 3'b010};
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0);
            n_total++;
            if ({playing, paused, track_changed} !== want[i] || actual() !== expected())
                $display("FAIL play_toggle[%0d]: got %b want %b", i, {playing, paused, track_changed}, want[i]);
            else n_pass++;
        end
        step(0, 0, 0, 1);
        n_total++;
        if (track !== 2'd3 || track_changed !== 1'b0 || paused !== 1'b1)
            $display("FAIL done_paused: got track %0d tc %b paused %b want 3 0 1", track, track_changed, paused);
        else n_pass++;
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        n_total++;
        if (track !== 2'd0 || track_changed !== 1'b1 || playing !== 1'b1 || actual() !== expected())
            $display("FAIL done_loop_wrap: got track %0d tc %b playing %b want 0 1 1", track, track_changed, playing);
        else n_pass++;
    endtask

    task automatic test_stop_at_end();
        mode = 2'd3;
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        n_total++;
        if (track !== 2'd0 || playing !== 1'b0 || paused !== 1'b0 || track_changed !== 1'b1)
            $display("FAIL stop_end_wrap: got track %0d play %b pause %b tc %b want 0 0 0 1", track, playing, paused, track_changed);
        else n_pass++;
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        n_total++;
        if (track !== 2'd2 || playing !== 1'b1 || actual() !== expected())
            $display("FAIL stop_end_mid: got track %0d play %b want 2 1", track, playing);
        else n_pass++;
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        n_total++;
        if (track !== 2'd0 || playing !== 1'b0 || paused !== 1'b0 || actual() !== expected())
            $display("FAIL stop_end_toggle: got track %0d play %b pause %b want 0 0 0", track, playing, paused);
        else n_pass++;
    endtask

    task automatic test_repeat_one();
        mode = 2'd1;
        step(0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        n_total++;
        if (track !== 2'd2 || track_changed !== 1'b1 || playing !== 1'b1)
            $display("FAIL repeat_restart: got track %0d tc %b want 2 1", track, track_changed);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (track !== 2'd2 || track_changed !== 1'b0)
            $display("FAIL repeat_once: got track %0d tc %b want 2 0", track, track_changed);
        else n_pass++;
    endtask

    task automatic test_shuffle();
        int pre[10];
        int cur;
        mode = 2'd2;
        for (int i = 0; i < 10; i++) begin
            pre[i] = int'(track);
            step(1, 0, 0, 0);
            n_total++;
            if (int'(track) == pre[i] || int'(track) >= N || actual() !== expected())
                $display("FAIL shuffle_pick[%0d]: got %0d (%h) from %0d want %h", i, track, actual(), pre[i], expected());
            else n_pass++;
        end
        n_total++;
        if (hist_count !== 4'd8) $display("FAIL shuffle_hist_sat: got %0d want 8", hist_count);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0);
            n_total++;
            if (int'(track) !== pre[9 - i] || int'(hist_count) !== 7 - i || track_changed !== 1'b1)
                $display("FAIL shuffle_retrace[%0d]: got %0d cnt %0d want %0d cnt %0d", i, track, hist_count, pre[9 - i], 7 - i);
            else n_pass++;
        end
        cur = int'(track);
        step(0, 1, 0, 0);
        n_total++;
        if (int'(track) !== dec(cur) || hist_count !== '0)
            $display("FAIL shuffle_empty_prev: got %0d want %0d", track, dec(cur));
        else n_pass++;
        repeat (3) step(1, 0, 0, 0);
        mode = 2'd0;
        step(0, 0, 0, 0);
        n_total++;
        if (hist_count !== '0 || actual() !== expected())
            $display("FAIL shuffle_clear: got cnt %0d want 0", hist_count);
        else n_pass++;
    endtask

    task automatic test_priority();
        int cur;
        mode = 2'd0;
        if (m_state != 1) step(0, 0, 1, 0);
        cur = int'(track);
        step(1, 1, 0, 1);
        n_total++;
        if (int'(track) !== inc(cur) || track_changed !== 1'b1)
            $display("FAIL prio_next: got %0d want %0d", track, inc(cur));
        else n_pass++;
        cur = int'(track);
        step(0, 1, 0, 1);
        n_total++;
        if (int'(track) !== dec(cur) || actual() !== expected())
            $display("FAIL prio_prev: got %0d want %0d", track, dec(cur));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        mode = 2'd2;
        repeat (4) step(1, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_total++;
        if (actual() !== '0) $display("FAIL reset_mid: got %h want 0", actual());
        else n_pass++;
        reset = 1'b0;
        repeat (3) step(1, 0, 0, 0);
        n_total++;
        if (actual() !== expected()) $display("FAIL reset_mid_resume: got %h want %h", actual(), expected());
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
            n_total++;
            if (actual() !== expected()) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got %h want %h (mode %0d)", i, actual(), expected(), mode);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_loop_next();
        test_play_state();
        test_stop_at_end();
        test_repeat_one();
        test_shuffle();
        test_priority();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
